stream_rr_arbiter: RTL and testbench

//  Shares one 16-bit valid/ready stream stage between NUM_REQ requesters (e.g. cipher cores).

---
 rtl/arb_pkg.sv | 30 +++
 rtl/rr_priority_picker.sv | 26 ++
 rtl/stream_rr_arbiter.sv | 116 +++++++++++
 tb/tb_stream_rr_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and round-robin pick function for stream arbiters
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int MAX_REQ       = 32;
  localparam int IDX_W         = $clog2(MAX_REQ);
  localparam int NUM_REQ_DEF   = 4;
  localparam int BURST_MAX_DEF = 8;
  localparam int GRANT_W       = $clog2(NUM_REQ_DEF);
  localparam int CNT_W         = $clog2(BURST_MAX_DEF + 1);

  // Scans last+1, last+2, ... (mod num_req). Walking the offsets downwards lets the
  // nearest valid index overwrite farther ones, so no early exit is needed.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] valid, input int num_req,
                                 input int last);
    int idx;
    rr_pick = last;
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= num_req) begin
        idx = (last + k) % num_req;
        if (valid[idx[IDX_W-1:0]]) rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational rotate/priority-encode of request valids
module rr_priority_picker
  import arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GRANT_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [GRANT_W-1:0] i_last,
  output logic               o_any_valid,
  output logic [GRANT_W-1:0] o_pick
);

  logic [MAX_REQ-1:0] w_valid_ext;
  int                 w_pick;

  always_comb begin
    w_valid_ext              = '0;
    w_valid_ext[NUM_REQ-1:0] = i_valid;
    w_pick                   = rr_pick(w_valid_ext, NUM_REQ, int'(i_last));
  end

  assign o_any_valid = |i_valid;
  assign o_pick      = GRANT_W'(w_pick);

endmodule

// File: rtl/stream_rr_arbiter.sv
// rtl/stream_rr_arbiter.sv - round-robin burst-locked arbiter onto one registered stream stage
module stream_rr_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 16,
  parameter int BURST_MAX = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_valid,
  output logic                         out_last,
  input  logic                         out_ready,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BURST_MAX + 1);

  arb_state_t        r_state;
  logic [GW-1:0]     r_grant_id;
  logic [GW-1:0]     r_last_grant;
  logic [CW-1:0]     r_beat_cnt;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_out_last;

  logic              w_any_valid;
  logic [GW-1:0]     w_pick;
  logic              w_slot_free;
  logic              w_accept;
  logic              w_release;
  logic [CW-1:0]     w_cnt_next;
  logic [DATA_W-1:0] w_sel_data;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .GRANT_W (GW)
  ) u_picker (
    .i_valid     (req_valid),
    .i_last      (r_last_grant),
    .o_any_valid (w_any_valid),
    .o_pick      (w_pick)
  );

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant_id == GW'(i)) w_sel_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  // The output slot can take a beat when empty or when its current beat leaves this cycle.
  assign w_slot_free = !r_out_valid || out_ready;
  assign w_accept    = (r_state == GRANT) && req_valid[r_grant_id] && w_slot_free;
  assign w_cnt_next  = r_beat_cnt + CW'(1);
  assign w_release   = req_last[r_grant_id] || (w_cnt_next == CW'(BURST_MAX));

  always_comb begin
    req_ready = '0;
    if (r_state == GRANT) req_ready[r_grant_id] = w_slot_free;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant_id   <= '0;
      r_last_grant <= GW'(NUM_REQ - 1);
      r_beat_cnt   <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_out_data  <= w_sel_data;
        r_out_last  <= req_last[r_grant_id];
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_any_valid) begin
            r_grant_id <= w_pick;
            r_beat_cnt <= '0;
            r_state    <= GRANT;
          end
        end
        GRANT: begin
          if (w_accept) begin
            r_beat_cnt <= w_cnt_next;
            if (w_release) begin
              r_last_grant <= r_grant_id;
              r_state      <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign grant_id  = r_grant_id;
  assign busy      = (r_state == GRANT);

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb/tb_stream_rr_arbiter.sv - self-checking bench for stream_rr_arbiter
module tb_stream_rr_arbiter;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int BM = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_last;
  logic            out_ready;
  logic [1:0]      grant_id;
  logic            busy;

  stream_rr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .BURST_MAX(BM)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_data  (req_data),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int vec  = 0;
  int miss = 0;
  int cyc  = 0;

  // Per-requester packet sources: {last, data}; the front entry is presented until taken.
  logic [16:0] src_q [NR][$];
  logic [NR-1:0] src_en;

  // Reference model: who owns the stage, rotation pointer, beats in grant, output slot.
  int          m_owner;
  int          m_ptr;
  int          m_gid;
  int          m_beats;
  logic        m_ov;
  logic        m_ol;
  logic [15:0] m_od;
  logic [3:0]  exp_rdy;
  logic [3:0]  obs_rdy;
  logic [8:0]  exp_stat;
  logic [8:0]  obs_stat;
  int          grant_log [$];
  int          grant_cyc [$];
  int          burst_log [$];
  logic [15:0] dut_out   [$];

  task automatic apply_inputs();
    for (int i = 0; i < NR; i++) begin
      if (src_en[i] && src_q[i].size() > 0) begin
        req_valid[i]          = 1'b1;
        req_last[i]           = src_q[i][0][16];
        req_data[i*DW +: DW]  = src_q[i][0][15:0];
      end else begin
        req_valid[i]          = 1'b0;
        req_last[i]           = 1'b0;
        req_data[i*DW +: DW]  = 16'h0;
      end
    end
  endtask

  task automatic model_update();
    int  o;
    logic slot;
    o    = m_owner;
    slot = !m_ov || out_ready;
    if (o >= 0) begin
      if (req_valid[o] && slot) begin
        m_od = req_data[o*DW +: DW];
        m_ol = req_last[o];
        m_ov = 1'b1;
        m_beats++;
        void'(src_q[o].pop_front());
        if (req_last[o] || m_beats == BM) begin
          m_ptr   = o;
          m_owner = -1;
          burst_log.push_back(m_beats);
        end
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
    end else begin
      if (out_ready) m_ov = 1'b0;
      for (int k = 1; k <= NR; k++) begin
        int i;
        i = (m_ptr + k) % NR;
        if (m_owner < 0 && req_valid[i]) begin
          m_owner = i;
          m_gid   = i;
          m_beats = 0;
          grant_log.push_back(i);
          grant_cyc.push_back(cyc);
        end
      end
    end
  endtask

  // One clock: drive, observe ready mid-cycle, step the model at the edge, observe outputs after.
  task automatic tick();
    apply_inputs();
    @(negedge clk);
    obs_rdy = req_ready;
    exp_rdy = (m_owner >= 0 && (!m_ov || out_ready)) ? 4'(1 << m_owner) : 4'b0;
    if (out_valid && out_ready) dut_out.push_back(out_data);
    @(posedge clk);
    model_update();
    cyc++;
    #1;
    obs_stat = {out_valid, out_last, grant_id, busy, obs_rdy};
    exp_stat = {m_ov, m_ol, 2'(m_gid), (m_owner >= 0), exp_rdy};
  endtask

  task automatic assert_reset();
    rst       = 1'b1;
    src_en    = '0;
    out_ready = 1'b1;
    for (int i = 0; i < NR; i++) src_q[i].delete();
    apply_inputs();
    m_owner = -1; m_ptr = NR - 1; m_gid = 0; m_beats = 0;
    m_ov = 1'b0; m_ol = 1'b0; m_od = 16'h0;
    grant_log.delete(); grant_cyc.delete(); burst_log.delete(); dut_out.delete();
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic load_pkt(input int i, input int len, input int base);
    for (int k = 0; k < len; k++)
      src_q[i].push_back({(k == len - 1), 4'(i), 12'(base + k)});
  endtask

  task automatic test_reset();
    assert_reset();
    repeat (2) @(posedge clk);
    #1;
    vec++;
    if ({out_valid, out_last, busy, grant_id, req_ready, out_data} !== 25'h0) begin
      miss++;
      $display("FAIL reset_hold ov=%b ol=%b busy=%b gid=%0d rdy=%b data=%h (want all 0)",
               out_valid, out_last, busy, grant_id, req_ready, out_data);
    end
    release_reset();
    vec++;
    if ({out_valid, busy, grant_id, req_ready} !== 8'h0) begin
      miss++;
      $display("FAIL reset_release ov=%b busy=%b gid=%0d rdy=%b (want 0)", out_valid, busy, grant_id, req_ready);
    end
    for (int i = 0; i < NR; i++) load_pkt(i, 5, 16 * i);
    src_en = '1;
    for (int c = 0; c < 7; c++) begin
      tick();
      vec++;
      if (obs_stat !== exp_stat || (m_ov && out_data !== m_od)) begin
        miss++;
        $display("FAIL reset_run cyc=%0d stat=%b want %b data=%h want %h", cyc, obs_stat, exp_stat, out_data, m_od);
      end
    end
    rst = 1'b1;
    #2;
    vec++;
    if ({out_valid, out_last, busy, grant_id, req_ready, out_data} !== 25'h0) begin
      miss++;
      $display("FAIL reset_midrun ov=%b ol=%b busy=%b gid=%0d rdy=%b data=%h (want all 0)",
               out_valid, out_last, busy, grant_id, req_ready, out_data);
    end
    assert_reset();
    release_reset();
    for (int i = 0; i < NR; i++) load_pkt(i, 1, 0);
    src_en = '1;
    tick();
    vec++;
    if (grant_id !== 2'd0 || busy !== 1'b1) begin
      miss++;
      $display("FAIL reset_first_grant gid=%0d busy=%b want gid=0 busy=1", grant_id, busy);
    end
  endtask

  task automatic test_single();
    logic [15:0] a [3];
    a[0] = 16'hA001; a[1] = 16'hA002; a[2] = 16'hA003;
    assert_reset();
    release_reset();
    for (int k = 0; k < 3; k++) src_q[0].push_back({(k == 2), a[k]});
    src_en = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      tick();
      vec++;
      if (obs_stat !== exp_stat || (m_ov && out_data !== m_od)) begin
        miss++;
        $display("FAIL single_model cyc=%0d stat=%b want %b data=%h want %h", cyc, obs_stat, exp_stat, out_data, m_od);
      end
      if (c == 0) begin
        vec++;
        if (grant_id !== 2'd0 || busy !== 1'b1 || out_valid !== 1'b0) begin
          miss++;
          $display("FAIL single_grant gid=%0d busy=%b ov=%b want 0/1/0", grant_id, busy, out_valid);
        end
      end
      if (c >= 1 && c <= 3) begin
        vec++;
        if (out_valid !== 1'b1 || out_data !== a[c-1] || out_last !== (c == 3)) begin
          miss++;
          $display("FAIL single_beat%0d ov=%b data=%h last=%b want 1/%h/%b", c, out_valid, out_data, out_last, a[c-1], (c == 3));
        end
      end
      if (c == 3) begin
        vec++;
        if (busy !== 1'b0) begin
          miss++;
          $display("FAIL single_release busy=%b want 0", busy);
        end
      end
    end
  endtask

  task automatic test_rotation();
    int exp_order [5];
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 3; exp_order[4] = 0;
    assert_reset();
    release_reset();
    for (int i = 0; i < NR; i++) load_pkt(i, 1, 32 + i);
    load_pkt(0, 1, 99);
    src_en = '1;
    for (int c = 0; c < 12; c++) begin
      tick();
      vec++;
      if (obs_stat !== exp_stat || (m_ov && out_data !== m_od)) begin
        miss++;
        $display("FAIL rotation_model cyc=%0d stat=%b want %b data=%h want %h", cyc, obs_stat, exp_stat, out_data, m_od);
      end
    end
    vec++;
    if (grant_log.size() != 5) begin
      miss++;
      $display("FAIL rotation_count grants=%0d want 5", grant_log.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        vec++;
        if (grant_log[k] != exp_order[k] || (k > 0 && grant_cyc[k] - grant_cyc[k-1] != 2)) begin
          miss++;
          $display("FAIL rotation_order%0d id=%0d want %0d", k, grant_log[k], exp_order[k]);
        end
      end
    end
  endtask

  task automatic test_burst_cap();
    assert_reset();
    release_reset();
    for (int k = 0; k < 20; k++) src_q[2].push_back({1'b0, 4'd2, 12'(k)});
    load_pkt(3, 3, 200);
    src_en = 4'b1100;
    for (int c = 0; c < 30; c++) begin
      tick();
      vec++;
      if (obs_stat !== exp_stat || (m_ov && out_data !== m_od)) begin
        miss++;
        $display("FAIL burst_model cyc=%0d stat=%b want %b data=%h want %h", cyc, obs_stat, exp_stat, out_data, m_od);
      end
    end
    vec++;
    if (grant_log.size() != 4 || burst_log.size() < 3) begin
      miss++;
      $display("FAIL burst_counts grants=%0d bursts=%0d want 4/3", grant_log.size(), burst_log.size());
    end else begin
      vec++;
      if (grant_log[0] != 2 || grant_log[1] != 3 || grant_log[2] != 2 || grant_log[3] != 2 ||
          burst_log[0] != BM || burst_log[1] != 3 || burst_log[2] != BM) begin
        miss++;
        $display("FAIL burst_order grants=%0d,%0d,%0d,%0d bursts=%0d,%0d,%0d want 2,3,2,2 / 8,3,8",
                 grant_log[0], grant_log[1], grant_log[2], grant_log[3], burst_log[0], burst_log[1], burst_log[2]);
      end
    end
  endtask

  task automatic test_backpressure();
    assert_reset();
    release_reset();
    load_pkt(1, 10, 1);
    src_en = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      out_ready = !(c >= 4 && c < 9);
      tick();
      vec++;
      if (obs_stat !== exp_stat || (m_ov && out_data !== m_od)) begin
        miss++;
        $display("FAIL bp_model cyc=%0d stat=%b want %b data=%h want %h", cyc, obs_stat, exp_stat, out_data, m_od);
      end
      if (c >= 4 && c < 9) begin
        vec++;
        if (out_valid !== 1'b1 || out_data !== 16'h1003 || obs_rdy !== 4'b0) begin
          miss++;
          $display("FAIL bp_hold c=%0d ov=%b data=%h rdy=%b want 1/1003/0000", c, out_valid, out_data, obs_rdy);
        end
      end
    end
    vec++;
    if (dut_out.size() != 10) begin
      miss++;
      $display("FAIL bp_count beats=%0d want 10", dut_out.size());
    end else begin
      for (int k = 0; k < 10; k++) begin
        vec++;
        if (dut_out[k] !== 16'h1000 + 16'(k + 1)) begin
          miss++;
          $display("FAIL bp_beat%0d data=%h want %h", k, dut_out[k], 16'h1000 + 16'(k + 1));
        end
      end
    end
  endtask

  task automatic test_stall();
    assert_reset();
    release_reset();
    load_pkt(0, 6, 1);
    load_pkt(2, 2, 50);
    for (int c = 0; c < 16; c++) begin
      src_en = (c >= 3 && c < 7) ? 4'b0100 : 4'b0101;
      tick();
      vec++;
      if (obs_stat !== exp_stat || (m_ov && out_data !== m_od)) begin
        miss++;
        $display("FAIL stall_model cyc=%0d stat=%b want %b data=%h want %h", cyc, obs_stat, exp_stat, out_data, m_od);
      end
      if (c >= 3 && c < 7) begin
        vec++;
        if (busy !== 1'b1 || grant_id !== 2'd0 || obs_rdy !== 4'b0001) begin
          miss++;
          $display("FAIL stall_hold c=%0d busy=%b gid=%0d rdy=%b want 1/0/0001", c, busy, grant_id, obs_rdy);
        end
      end
    end
    vec++;
    if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 2) begin
      miss++;
      $display("FAIL stall_order grants=%0d want sequence 0,2", grant_log.size());
    end
  endtask

  task automatic test_random();
    assert_reset();
    release_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++)
        if (src_q[i].size() == 0) load_pkt(i, $urandom_range(1, 12), $urandom_range(0, 4000));
      src_en    = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      vec++;
      if (obs_stat !== exp_stat || (m_ov && out_data !== m_od)) begin
        miss++;
        $display("FAIL random_model cyc=%0d stat=%b want %b data=%h want %h", cyc, obs_stat, exp_stat, out_data, m_od);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    src_en    = '0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    test_reset();
    test_single();
    test_rotation();
    test_burst_cap();
    test_backpressure();
    test_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
